// File: rtl/ap_ctrl_rr_arbiter_pkg.sv
// ap_ctrl_rr_arbiter_pkg: state encoding and width helper shared by the arbiter slice
package ap_ctrl_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b11,
        RESP  = 2'b10
    } state_t;

    // Index width for n entries, never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ap_ctrl_rr_arbiter_rr_pick.sv
// ap_ctrl_rr_arbiter_rr_pick: combinational round-robin priority encoder
module ap_ctrl_rr_arbiter_rr_pick
    import ap_ctrl_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               valid,
    output logic [IW-1:0]      index
);

    int k;
    logic [IW-1:0] kk;

    // Scan downward in distance from rr_ptr so the closest requester is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        k = 0;
        kk = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            kk = IW'(k);
            if (req[kk]) begin
                valid = 1'b1;
                index = kk;
            end
        end
    end

endmodule

// File: rtl/ap_ctrl_rr_arbiter.sv
// ap_ctrl_rr_arbiter: shares one ap_ctrl_hs child among NUM_REQ requesters, round-robin
module ap_ctrl_rr_arbiter
    import ap_ctrl_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ARG_WIDTH = 64,
    parameter int CNT_WIDTH = 32,
    localparam int IW = clog2(NUM_REQ)
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_ap_start,
    input  logic [NUM_REQ*ARG_WIDTH-1:0] req_arg,
    output logic [NUM_REQ-1:0]           req_ap_ready,
    output logic [NUM_REQ-1:0]           req_ap_done,
    output logic [NUM_REQ-1:0]           req_ap_idle,
    output logic                         child_ap_start,
    output logic [ARG_WIDTH-1:0]         child_arg,
    input  logic                         child_ap_ready,
    input  logic                         child_ap_done,
    input  logic                         child_ap_idle,
    output logic [IW-1:0]                grant_id,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         done_count
);

    state_t state, state_nx;
    logic [IW-1:0] rr_ptr;
    logic pick_valid;
    logic [IW-1:0] pick_idx;
    logic [ARG_WIDTH-1:0] args [NUM_REQ];
    logic [NUM_REQ-1:0] grant_oh;
    logic unused_ok;

    // Child idle is informational only; sequencing relies on ready/done.
    assign unused_ok = child_ap_idle;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_arg
        assign args[i] = req_arg[i*ARG_WIDTH +: ARG_WIDTH];
    end

    ap_ctrl_rr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req_ap_start),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    assign grant_oh = NUM_REQ'(1) << grant_id;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            child_arg  <= '0;
            done_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_valid) begin
                grant_id  <= pick_idx;
                child_arg <= args[pick_idx];
            end
            if (state == RESP) begin
                rr_ptr     <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                done_count <= done_count + 1'b1;
            end
        end
    end

    // A done seen in START without ready belongs to nothing we launched, so it is dropped.
    always_comb begin
        state_nx       = state;
        child_ap_start = 1'b0;
        req_ap_ready   = '0;
        req_ap_done    = '0;
        unique case (state)
            IDLE:  state_nx = pick_valid ? START : IDLE;
            START: begin
                child_ap_start = 1'b1;
                req_ap_ready   = child_ap_ready ? grant_oh : '0;
                state_nx       = !child_ap_ready ? START : child_ap_done ? RESP : WAIT;
            end
            WAIT:  state_nx = child_ap_done ? RESP : WAIT;
            RESP: begin
                req_ap_done = grant_oh;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy        = state != IDLE;
        req_ap_idle = busy ? ~grant_oh : '1;
    end

endmodule

// File: tb/tb_ap_ctrl_rr_arbiter.sv
// tb_ap_ctrl_rr_arbiter: randomized requesters and child against a transaction-level scoreboard
module tb_ap_ctrl_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int CW = 4;
    localparam int IW = 2;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic [N-1:0] req_ap_start, req_ap_ready, req_ap_done, req_ap_idle;
    logic [N*AW-1:0] req_arg;
    logic child_ap_start, child_ap_ready, child_ap_done, child_ap_idle;
    logic [AW-1:0] child_arg;
    logic [IW-1:0] grant_id;
    logic busy;
    logic [CW-1:0] done_count;

    always #5 ap_clk = ~ap_clk;

    ap_ctrl_rr_arbiter #(.NUM_REQ(N), .ARG_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .req_ap_start   (req_ap_start),
        .req_arg        (req_arg),
        .req_ap_ready   (req_ap_ready),
        .req_ap_done    (req_ap_done),
        .req_ap_idle    (req_ap_idle),
        .child_ap_start (child_ap_start),
        .child_arg      (child_arg),
        .child_ap_ready (child_ap_ready),
        .child_ap_done  (child_ap_done),
        .child_ap_idle  (child_ap_idle),
        .grant_id       (grant_id),
        .busy           (busy),
        .done_count     (done_count)
    );

    typedef struct { int idx; logic [AW-1:0] arg; } rd_t;
    typedef struct { int idx; int cnt; } dn_t;
    rd_t exp_rd[$];
    dn_t exp_dn[$];
    int vectors = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole invocations planned as timelines (grant, accept, done cycles).
    int ptr, cnt, gw, g, acc, dn, next_free, w, prob, nrst;
    logic [N-1:0] pend;
    logic [AW-1:0] args [N];

    initial begin
        ptr = 0; cnt = 0; gw = -1; g = 0; acc = 0; dn = 0; next_free = 0; w = 0; prob = 0; nrst = 0;
        pend = '0;
        for (int i = 0; i < N; i++) args[i] = '0;
        ap_rst = 1'b1;
        req_ap_start = '0;
        req_arg = '0;
        child_ap_ready = 1'b0;
        child_ap_done = 1'b0;
        child_ap_idle = 1'b1;
        repeat (3) @(posedge ap_clk);
        for (int c = 0; c < 3040; c++) begin
            @(posedge ap_clk);
            #1;
            ap_rst = 1'b0;
            prob = c < 1000 ? 15 : c < 2000 ? 95 : c < 3000 ? 40 : 0;
            if (gw >= 0 && c == acc + 1) pend[gw] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(9) == 0) args[i] = {$urandom, $urandom};
                if (c >= 3000) pend[i] = 1'b0;
                else if (!pend[i] && $urandom_range(99) < prob) pend[i] = 1'b1;
                else if (pend[i] && !(gw == i && c <= acc) && $urandom_range(99) < 2) pend[i] = 1'b0;
            end
            if (gw >= 0 && c > acc && c < dn && nrst < 5 && $urandom_range(19) == 0) begin
                ap_rst = 1'b1;
                nrst++;
                exp_dn.delete();
                ptr = 0; cnt = 0; gw = -1; next_free = c + 1;
            end else if (c >= next_free && pend != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
                gw = w; g = c;
                acc = c + 1 + int'($urandom_range(4));
                dn = acc + int'($urandom_range(3));
                exp_rd.push_back('{w, args[w]});
                exp_dn.push_back('{w, cnt});
                cnt = (cnt + 1) % (1 << CW);
                ptr = (w + 1) % N;
                next_free = dn + 2;
            end
            child_ap_ready = gw >= 0 && c == acc;
            child_ap_done = gw >= 0 && (c == dn || (c > g && c < acc && $urandom_range(3) == 0));
            child_ap_idle = 1'($urandom_range(1));
            req_ap_start = pend;
            for (int i = 0; i < N; i++) req_arg[i*AW +: AW] = args[i];
        end
        @(negedge ap_clk);
        #1;
        chk("accepts_outstanding", AW'(exp_rd.size()), '0);
        chk("dones_outstanding", AW'(exp_dn.size()), '0);
        chk("final_done_count", AW'(done_count), AW'(cnt));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    logic prev_rst = 1'b0;
    rd_t er;
    dn_t ed;
    logic [N-1:0] oh, ioh;

    always @(negedge ap_clk) begin
        if (!ap_rst && prev_rst) begin
            chk("rst_busy", AW'(busy), '0);
            chk("rst_child_start", AW'(child_ap_start), '0);
            chk("rst_ready", AW'(req_ap_ready), '0);
            chk("rst_done", AW'(req_ap_done), '0);
            chk("rst_idle", AW'(req_ap_idle), AW'({N{1'b1}}));
            chk("rst_done_count", AW'(done_count), '0);
            chk("rst_grant_id", AW'(grant_id), '0);
            chk("rst_child_arg", child_arg, '0);
        end else if (!ap_rst) begin
            if (child_ap_ready) begin
                chk("start_at_accept", AW'(child_ap_start), AW'(1));
                if (exp_rd.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL accept_unplanned: req_ap_ready=%b, required no invocation", req_ap_ready);
                end else begin
                    er = exp_rd.pop_front();
                    oh = N'(1) << er.idx;
                    ioh = ~oh;
                    chk("ready_onehot", AW'(req_ap_ready), AW'(oh));
                    chk("grant_id", AW'(grant_id), AW'(er.idx));
                    chk("child_arg", child_arg, er.arg);
                    chk("idle_in_flight", AW'(req_ap_idle), AW'(ioh));
                    chk("busy_in_flight", AW'(busy), AW'(1));
                end
            end else begin
                chk("ready_quiet", AW'(req_ap_ready), '0);
            end
            if (req_ap_done != '0) begin
                if (exp_dn.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL done_unplanned: req_ap_done=%b, required 0", req_ap_done);
                end else begin
                    ed = exp_dn.pop_front();
                    oh = N'(1) << ed.idx;
                    chk("done_onehot", AW'(req_ap_done), AW'(oh));
                    chk("done_count", AW'(done_count), AW'(ed.cnt));
                    chk("done_grant_id", AW'(grant_id), AW'(ed.idx));
                end
            end
        end
        prev_rst = ap_rst;
    end

endmodule
